// File: rtl/pool_sched.sv
// Sequencer feeding a 2x2 max-pooling unit: buffers each even row, interleaves it
// beat-by-beat with the odd row, and turns pooled (or bypassed) beats into writes.
module pool_sched #(
  parameter int POX       = 4,
  parameter int MAX_TILES = 64,
  parameter int DIM_W     = 8,
  parameter int ADDR_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cfg_pool_en,
  input  logic [DIM_W-1:0]      cfg_tiles,
  input  logic [DIM_W-1:0]      cfg_rows,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [POX*16-1:0]     post_data,
  input  logic                  post_valid,
  output logic                  post_ready,
  output logic [POX*16-1:0]     pool_data,
  output logic                  pool_valid,
  input  logic [POX/2*16-1:0]   pool_result,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [POX*16-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BW    = POX * 16;
  localparam int PW    = (POX / 2) * 16;
  localparam int IDX_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

  typedef enum logic [2:0] {IDLE, EVEN, ODD_A, ODD_B, FLUSH, BYPASS, FIN} state_t;

  state_t            state_q, next_state;
  logic              pool_en_q;
  logic [DIM_W-1:0]  tiles_q, rows_q, tile_q, row_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     hold_q, byp_data_q;
  logic              wr_q, wr_pool_q;
  logic [BW-1:0]     linebuf [MAX_TILES];
  logic [IDX_W-1:0]  buf_idx;
  logic              accept, last_tile, last_row, odd_tail, rows_done;

  assign buf_idx    = tile_q[IDX_W-1:0];
  assign post_ready = (state_q == EVEN) || (state_q == ODD_A) || (state_q == BYPASS);
  assign accept     = post_valid && post_ready;
  assign last_tile  = (tile_q == tiles_q - DIM_W'(1));
  assign last_row   = (row_q == rows_q - DIM_W'(1));
  // Only one row left after this even fill: it has no partner and is dropped.
  assign odd_tail   = ({1'b0, row_q} + (DIM_W+1)'(1)) >= {1'b0, rows_q};
  assign rows_done  = (row_q >= rows_q);

  assign pool_valid = ((state_q == ODD_A) && post_valid) || (state_q == ODD_B);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign wr_en      = wr_q;
  assign wr_addr    = addr_q;

  // Buffered even beat goes out combinationally alongside the accepted odd beat.
  always_comb begin
    pool_data = '0;
    if ((state_q == ODD_A) && post_valid) pool_data = linebuf[buf_idx];
    else if (state_q == ODD_B)            pool_data = hold_q;
  end

  // Pooled writes take the pooling unit's registered result, one cycle after ODD_B.
  always_comb begin
    wr_data = '0;
    if (wr_q) wr_data = wr_pool_q ? {{(BW-PW){1'b0}}, pool_result} : byp_data_q;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_pool_en && (cfg_rows >= DIM_W'(2)) && (cfg_tiles != '0))       next_state = EVEN;
        else if (!cfg_pool_en && (cfg_rows != '0) && (cfg_tiles != '0))        next_state = BYPASS;
        else                                                                   next_state = FIN;
      end
      EVEN:   if (accept && last_tile) next_state = odd_tail ? FIN : ODD_A;
      ODD_A:  if (accept) next_state = ODD_B;
      ODD_B:  next_state = last_tile ? FLUSH : ODD_A;
      FLUSH:  next_state = (!pool_en_q || rows_done) ? FIN : EVEN;
      BYPASS: if (accept && last_tile && last_row) next_state = FLUSH;
      FIN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the line buffer is pure storage and deliberately has no reset.
  always_ff @(posedge clk) begin
    if ((state_q == EVEN) && accept) linebuf[buf_idx] <= post_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pool_en_q  <= 1'b0;
      tiles_q    <= '0;
      rows_q     <= '0;
      tile_q     <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      hold_q     <= '0;
      byp_data_q <= '0;
      wr_q       <= 1'b0;
      wr_pool_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      state_q   <= next_state;
      wr_q      <= 1'b0;
      wr_pool_q <= 1'b0;
      if (wr_q) addr_q <= addr_q + ADDR_W'(1);
      case (state_q)
        IDLE: if (start) begin
          pool_en_q <= cfg_pool_en;
          tiles_q   <= cfg_tiles;
          rows_q    <= cfg_rows;
          addr_q    <= cfg_base;
          tile_q    <= '0;
          row_q     <= '0;
        end
        EVEN: if (accept) tile_q <= last_tile ? '0 : tile_q + DIM_W'(1);
        ODD_A: if (accept) hold_q <= post_data;
        ODD_B: begin
          wr_q      <= 1'b1;
          wr_pool_q <= 1'b1;
          if (last_tile) begin
            tile_q <= '0;
            row_q  <= row_q + DIM_W'(2);
          end else begin
            tile_q <= tile_q + DIM_W'(1);
          end
        end
        BYPASS: if (accept) begin
          wr_q       <= 1'b1;
          byp_data_q <= post_data;
          if (last_tile) begin
            tile_q <= '0;
            row_q  <= row_q + DIM_W'(1);
          end else begin
            tile_q <= tile_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_sched.sv
// Bench for pool_sched: table of layer configs with random beats checked against a
// row/column reference model, plus hand sequences for the worked example and reset.
module tb_pool_sched;
  localparam int POX = 4, MAX_TILES = 64, DIM_W = 8, ADDR_W = 12;

  logic                 clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_pool_en = 1'b0;
  logic [DIM_W-1:0]     cfg_tiles = '0, cfg_rows = '0;
  logic [ADDR_W-1:0]    cfg_base = '0;
  logic [POX*16-1:0]    post_data = '0;
  logic                 post_valid = 1'b0;
  logic                 post_ready, pool_valid, wr_en, busy, done;
  logic [POX*16-1:0]    pool_data, wr_data;
  logic [POX/2*16-1:0]  pool_result;
  logic [ADDR_W-1:0]    wr_addr;

  pool_sched #(.POX(POX), .MAX_TILES(MAX_TILES), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pool_en(cfg_pool_en),
    .cfg_tiles(cfg_tiles), .cfg_rows(cfg_rows), .cfg_base(cfg_base),
    .post_data(post_data), .post_valid(post_valid), .post_ready(post_ready),
    .pool_data(pool_data), .pool_valid(pool_valid), .pool_result(pool_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pooling-unit stand-in: pairs consecutive valid beats, registers max on the second.
  logic [63:0] pu_first;
  bit          pu_phase;
  function automatic logic [31:0] pool2x2(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] r;
    logic [15:0] m;
    for (int j = 0; j < 2; j++) begin
      m = a[32*j +: 16];
      if (a[32*j+16 +: 16] > m) m = a[32*j+16 +: 16];
      if (b[32*j +: 16] > m)    m = b[32*j +: 16];
      if (b[32*j+16 +: 16] > m) m = b[32*j+16 +: 16];
      r[16*j +: 16] = m;
    end
    return r;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pu_phase <= 1'b0; pu_first <= '0; pool_result <= '0;
    end else if (pool_valid) begin
      if (!pu_phase) pu_first <= pool_data;
      else           pool_result <= pool2x2(pu_first, pool_data);
      pu_phase <= !pu_phase;
    end
  end

  // Monitor: records accepts, writes, pool_valid pairing and done at the falling edge.
  logic [63:0] acc_d[$], wr_d[$];
  logic [11:0] wr_a[$];
  int acc_c[$], wr_c[$], pv2_c[$];
  int pv_cnt, pv_err, done_cnt, done_c, busy_err;
  bit pv_phase, prev_pv, clr, arm;
  always @(negedge clk) begin
    if (clr) begin
      acc_d.delete(); wr_d.delete(); wr_a.delete(); acc_c.delete(); wr_c.delete(); pv2_c.delete();
      pv_cnt = 0; pv_err = 0; done_cnt = 0; done_c = 0; busy_err = 0; pv_phase = 0; prev_pv = 0;
    end else if (rst_n) begin
      if (post_valid && post_ready) begin acc_d.push_back(post_data); acc_c.push_back(cyc); end
      if (wr_en) begin wr_a.push_back(wr_addr); wr_d.push_back(wr_data); wr_c.push_back(cyc); end
      if (pool_valid) begin
        if (pv_phase) begin
          if (!prev_pv || post_ready) pv_err++;
          pv2_c.push_back(cyc);
        end
        pv_cnt++;
        pv_phase = !pv_phase;
      end else if (pv_phase) pv_err++;
      prev_pv = pool_valid;
      if (arm && !busy && done_cnt == 0) busy_err++;
      if (done) begin done_cnt++; done_c = cyc; end
    end
  end

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit pe; int tiles; int rows; logic [11:0] base; int gap; bit restart; int exp_wr;
  } layer_vec_t;
  typedef struct { logic [11:0] addr; logic [63:0] data; } wr_vec_t;

  logic [63:0] beats[$], exp_d[$];
  logic [11:0] exp_a[$];
  int start_c;

  function automatic logic [63:0] mk(input int p0, p1, p2, p3);
    return {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  // Reference: rows of beats, pooled over row pairs and adjacent pixel pairs.
  task automatic build_exp(input layer_vec_t v);
    logic [63:0] e, o, d;
    int k = 0, m;
    exp_a.delete(); exp_d.delete();
    if (v.pe && v.tiles >= 1 && v.rows >= 2) begin
      for (int p = 0; p < v.rows / 2; p++)
        for (int t = 0; t < v.tiles; t++) begin
          e = beats[(2*p)*v.tiles + t];
          o = beats[(2*p+1)*v.tiles + t];
          d = '0;
          for (int j = 0; j < POX / 2; j++) begin
            m = 0;
            for (int q = 0; q < 2; q++) begin
              if (int'(e[16*(2*j+q) +: 16]) > m) m = int'(e[16*(2*j+q) +: 16]);
              if (int'(o[16*(2*j+q) +: 16]) > m) m = int'(o[16*(2*j+q) +: 16]);
            end
            d[16*j +: 16] = 16'(m);
          end
          exp_d.push_back(d); exp_a.push_back(12'(int'(v.base) + k)); k++;
        end
    end else if (!v.pe && v.tiles >= 1 && v.rows >= 1) begin
      for (int i = 0; i < v.tiles * v.rows; i++) begin
        exp_d.push_back(beats[i]); exp_a.push_back(12'(int'(v.base) + i));
      end
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic run_layer(input layer_vec_t v, output bit timed_out);
    int idx = 0;
    clear_mon();
    @(posedge clk); #1;
    cfg_pool_en = v.pe; cfg_tiles = DIM_W'(v.tiles); cfg_rows = DIM_W'(v.rows); cfg_base = v.base;
    start = 1'b1; start_c = cyc;
    @(posedge clk); #1;
    start = 1'b0; arm = 1'b1; timed_out = 1'b1;
    for (int n = 0; n < v.tiles * v.rows * 4 + 40; n++) begin
      if (idx < beats.size() && $urandom_range(99) >= v.gap) begin
        post_valid = 1'b1; post_data = beats[idx];
      end else post_valid = 1'b0;
      if (v.restart && n == 4) begin
        start = 1'b1; cfg_pool_en = !v.pe; cfg_tiles = 8'd1; cfg_rows = 8'd2;
      end
      @(negedge clk); #1;
      if (post_valid && post_ready) idx++;
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    post_valid = 1'b0; start = 1'b0; arm = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic run_and_check(input layer_vec_t v, input string tag);
    bit to;
    int exp_acc, terr = 0;
    beats.delete();
    for (int i = 0; i < v.tiles * v.rows; i++) beats.push_back({$urandom, $urandom});
    build_exp(v);
    run_layer(v, to);
    exp_acc = ((v.tiles >= 1) && (v.pe ? v.rows >= 2 : v.rows >= 1)) ? v.tiles * v.rows : 0;
    check({tag, "_timeout"}, 64'(to), 0);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_wr_count"}, wr_d.size(), v.exp_wr);
    check({tag, "_acc_count"}, acc_d.size(), exp_acc);
    for (int i = 0; i < exp_d.size(); i++)
      if (i < wr_d.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wr_a[i], exp_a[i]);
        check($sformatf("%s_data%0d", tag, i), wr_d[i], exp_d[i]);
      end
    check({tag, "_pv_count"}, pv_cnt, v.pe ? 2 * v.exp_wr : 0);
    check({tag, "_pv_pairing"}, pv_err, 0);
    check({tag, "_busy_span"}, busy_err, 0);
    for (int i = 0; i < wr_c.size(); i++)
      if (v.pe ? (i >= pv2_c.size() || wr_c[i] != pv2_c[i] + 1)
               : (i >= acc_c.size() || wr_c[i] != acc_c[i] + 1)) terr++;
    check({tag, "_wr_timing"}, terr, 0);
    if (wr_c.size() > 0) check({tag, "_done_after_wr"}, 64'(done_c > wr_c[wr_c.size()-1]), 1);
    if (exp_acc == 0) check({tag, "_done_latency"}, 64'(done_c - start_c >= 1 && done_c - start_c <= 2), 1);
    check({tag, "_idle_after"}, {busy, done, wr_en, post_ready}, 0);
  endtask

  layer_vec_t lv[8];
  wr_vec_t    t1[2];
  layer_vec_t v;
  bit         to, found;
  int         idx;

  initial begin
    lv[0] = '{pe:1, tiles:3, rows:5, base:12'h100, gap:0,  restart:0, exp_wr:6};
    lv[1] = '{pe:0, tiles:2, rows:3, base:12'hFFE, gap:0,  restart:0, exp_wr:6};
    lv[2] = '{pe:1, tiles:1, rows:1, base:12'h000, gap:0,  restart:0, exp_wr:0};
    lv[3] = '{pe:1, tiles:0, rows:4, base:12'h000, gap:0,  restart:0, exp_wr:0};
    lv[4] = '{pe:1, tiles:3, rows:4, base:12'h020, gap:40, restart:1, exp_wr:6};
    lv[5] = '{pe:0, tiles:0, rows:3, base:12'h000, gap:0,  restart:0, exp_wr:0};
    lv[6] = '{pe:1, tiles:4, rows:6, base:12'hFFC, gap:30, restart:0, exp_wr:12};
    lv[7] = '{pe:0, tiles:3, rows:2, base:12'h300, gap:50, restart:0, exp_wr:6};
    // Lane 0 = max(1,8,9,0), lane 1 = max(3,4,0,1); then max(5,6,2,2), max(7,2,2,2).
    t1[0] = '{addr:12'h010, data:{32'd0, 16'd4, 16'd9}};
    t1[1] = '{addr:12'h011, data:{32'd0, 16'd7, 16'd6}};

    #1;
    check("reset_outputs", {post_ready, pool_valid, wr_en, busy, done}, 0);
    check("reset_addr", wr_addr, 0);
    check("reset_data", wr_data | pool_data, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    // Worked example: 2 tiles x 2 rows.
    beats = '{mk(1,8,3,4), mk(5,6,7,2), mk(9,0,0,1), mk(2,2,2,2)};
    v = '{pe:1, tiles:2, rows:2, base:12'h010, gap:0, restart:0, exp_wr:2};
    run_layer(v, to);
    check("ex_timeout", 64'(to), 0);
    check("ex_wr_count", wr_d.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < wr_d.size()) begin
        check($sformatf("ex_addr%0d", i), wr_a[i], t1[i].addr);
        check($sformatf("ex_data%0d", i), wr_d[i], t1[i].data);
      end
    if (wr_c.size() > 0) check("ex_done_timing", done_c, wr_c[wr_c.size()-1] + 1);
    check("ex_pv_pairing", pv_err, 0);
    check("ex_pv_count", pv_cnt, 4);

    for (int i = 0; i < 8; i++) run_and_check(lv[i], $sformatf("vec%0d", i));

    // Reset asserted while the DUT sits in the second beat of a pair.
    clear_mon();
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back({$urandom, $urandom});
    @(posedge clk); #1;
    cfg_pool_en = 1'b1; cfg_tiles = 8'd2; cfg_rows = 8'd2; cfg_base = 12'h010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; idx = 0; found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      post_valid = (idx < beats.size());
      if (idx < beats.size()) post_data = beats[idx];
      @(negedge clk); #1;
      if (pool_valid && !post_ready) found = 1'b1;
      else begin
        if (post_valid && post_ready) idx++;
        @(posedge clk); #1;
      end
    end
    check("rst_reached_odd_b", 64'(found), 1);
    rst_n = 1'b0; post_valid = 1'b0;
    #1;
    check("rst_ctrl_zero", {post_ready, pool_valid, wr_en, busy, done}, 0);
    check("rst_addr_zero", wr_addr, 0);
    check("rst_pool_data_zero", pool_data, 0);
    check("rst_wr_data_zero", wr_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{pe:1, tiles:1, rows:2, base:12'h0AB, gap:0, restart:0, exp_wr:1};
    run_and_check(v, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
